// File: rtl/size_count_pkg.sv
// Shared FSM encodings and a constant log2 helper for the payload-length tracker.
// No logic, no latency, no flow control.
package size_count_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARMED = 2'd1;
   localparam state_t ST_COUNT = 2'd2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/size_count_multi_if.sv
// Size-queue, beat and error signals between header parser, tracker and checksum unit.
// master drives sizes/beats/clears; slave (the tracker) returns status and pulses.
interface size_count_multi_if #(
   parameter int SIZE_W     = 32,
   parameter int BEAT_BYTES = 4,
   parameter int DEPTH      = 4
);
   localparam int LB_W   = size_count_pkg::clog2(BEAT_BYTES) + 1;
   localparam int PEND_W = size_count_pkg::clog2(DEPTH) + 1;

   logic              size_valid;
   logic [SIZE_W-1:0] size;
   logic              size_ready;
   logic              data_start;
   logic              data_valid;
   logic              last_beat;
   logic [LB_W-1:0]   last_bytes;
   logic              checksum_valid;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              err_clear;
   logic              err_overflow;
   logic              err_start;

   modport master (
      output size_valid, size, data_start, data_valid, err_clear,
      input  size_ready, last_beat, last_bytes, checksum_valid, busy, pending,
             err_overflow, err_start
   );

   modport slave (
      input  size_valid, size, data_start, data_valid, err_clear,
      output size_ready, last_beat, last_bytes, checksum_valid, busy, pending,
             err_overflow, err_start
   );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pushes when full and pops when empty are ignored.
// Head data is combinational from the read pointer; occupancy updates one cycle after push/pop.
module sync_fifo import size_count_pkg::*; #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head_data,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count
);
   localparam int AW = clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end
endmodule

// File: rtl/size_count_multi.sv
// Queues payload sizes, counts qualified beats per payload, pulses checksum_valid one cycle after the final beat.
// size_ready drops when the queue is full; overflowing sizes and misplaced starts set sticky error flags.
module size_count_multi import size_count_pkg::*; #(
   parameter int SIZE_W     = 32,
   parameter int BEAT_BYTES = 4,
   parameter int DEPTH      = 4
) (
   input logic               clock,
   input logic               rst_n,
   size_count_multi_if.slave bus
);
   localparam int LOG_BB = clog2(BEAT_BYTES);
   localparam int LB_W   = LOG_BB + 1;
   localparam int PEND_W = clog2(DEPTH) + 1;
   localparam int CNT_W  = SIZE_W + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [LB_W-1:0]   lb_q;
   logic              cv_q, err_ovf_q, err_start_q;

   logic              fifo_full, fifo_empty;
   logic [PEND_W-1:0] fifo_count;
   logic [SIZE_W-1:0] head;
   logic              push_ok, pop, last_beat, busy;
   logic [CNT_W-1:0]  beats;
   logic [SIZE_W-1:0] rem;
   logic [LB_W-1:0]   lb_calc;

   assign push_ok = bus.size_valid && !fifo_full;

   sync_fifo #(.W(SIZE_W), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .push      (bus.size_valid),
      .push_data (bus.size),
      .pop       (pop),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // One extra bit keeps the round-up from wrapping at the maximum size.
   assign beats   = ({1'b0, head} + CNT_W'(BEAT_BYTES - 1)) >> LOG_BB;
   assign rem     = head & SIZE_W'(BEAT_BYTES - 1);
   assign lb_calc = (rem == '0) ? LB_W'(BEAT_BYTES) : LB_W'(rem);

   always_ff @(posedge clock) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (push_ok) state_d = ST_ARMED;
         ST_ARMED: if (pop) begin
            if (beats == '0)
               state_d = (fifo_count > PEND_W'(1) || push_ok) ? ST_ARMED : ST_IDLE;
            else
               state_d = ST_COUNT;
         end
         ST_COUNT: if (last_beat)
            state_d = (fifo_count != '0 || push_ok) ? ST_ARMED : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pop       = 1'b0;
      busy      = 1'b0;
      last_beat = 1'b0;
      case (state_q)
         ST_ARMED: pop = bus.data_start && !fifo_empty;
         ST_COUNT: begin
            busy      = 1'b1;
            last_beat = bus.data_valid && (cnt_q == CNT_W'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         lb_q        <= LB_W'(BEAT_BYTES);
         cv_q        <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_start_q <= 1'b0;
      end else begin
         if (pop && beats != '0)         cnt_q <= beats;
         else if (busy && bus.data_valid) cnt_q <= cnt_q - CNT_W'(1);
         if (pop) lb_q <= lb_calc;
         cv_q <= (pop && beats == '0) || last_beat;
         // Clear wins over a same-cycle error.
         if (bus.err_clear)                    err_ovf_q <= 1'b0;
         else if (bus.size_valid && fifo_full) err_ovf_q <= 1'b1;
         if (bus.err_clear)                                err_start_q <= 1'b0;
         else if (bus.data_start && state_q != ST_ARMED)   err_start_q <= 1'b1;
      end
   end

   assign bus.size_ready     = !fifo_full;
   assign bus.last_beat      = last_beat;
   assign bus.last_bytes     = lb_q;
   assign bus.checksum_valid = cv_q;
   assign bus.busy           = busy;
   assign bus.pending        = fifo_count;
   assign bus.err_overflow   = err_ovf_q;
   assign bus.err_start      = err_start_q;
endmodule

// File: tb/tb_size_count_multi.sv
// Directed bench for size_count_multi with BEAT_BYTES=4, DEPTH=4; expected values are hand-computed.
module tb_size_count_multi;
   localparam int SIZE_W     = 32;
   localparam int BEAT_BYTES = 4;
   localparam int DEPTH      = 4;

   logic clock = 1'b0;
   logic rst_n;
   int   tests   = 0;
   int   fails   = 0;
   int   cv_seen = 0;
   int   cv_exp  = 0;

   always #5 clock = ~clock;

   size_count_multi_if #(.SIZE_W(SIZE_W), .BEAT_BYTES(BEAT_BYTES), .DEPTH(DEPTH)) bus ();

   size_count_multi #(.SIZE_W(SIZE_W), .BEAT_BYTES(BEAT_BYTES), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(negedge clock) if (rst_n && bus.checksum_valid) cv_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int sz);
      bus.size_valid = 1'b1;
      bus.size       = sz;
      tick;
      bus.size_valid = 1'b0;
   endtask

   // Starts the head payload from ARMED and streams its beats back-to-back.
   task automatic run_payload(input int beats, input int lb, input int pend, input string tag);
      bus.data_start = 1'b1;
      tick;
      bus.data_start = 1'b0;
      chk({tag, "_pending"}, bus.pending, pend);
      if (beats == 0) begin
         #1;
         chk({tag, "_cv"}, bus.checksum_valid, 1);
         chk({tag, "_busy"}, bus.busy, 0);
      end else begin
         chk({tag, "_busy"}, bus.busy, 1);
         chk({tag, "_last_bytes"}, bus.last_bytes, lb);
         for (int i = 0; i < beats; i++) begin
            bus.data_valid = 1'b1;
            #1;
            chk({tag, "_last_beat"}, bus.last_beat, (i == beats - 1));
            tick;
         end
         bus.data_valid = 1'b0;
         #1;
         chk({tag, "_cv"}, bus.checksum_valid, 1);
      end
      cv_exp++;
   endtask

   initial begin
      int sizes [5] = '{5, 8, 11, 16, 20};
      rst_n          = 1'b0;
      bus.size_valid = 1'b0;
      bus.size       = '0;
      bus.data_start = 1'b0;
      bus.data_valid = 1'b0;
      bus.err_clear  = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
      chk("rst_pending", bus.pending, 0);
      chk("rst_size_ready", bus.size_ready, 1);
      chk("rst_cv", bus.checksum_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err_ovf", bus.err_overflow, 0);
      chk("rst_err_start", bus.err_start, 0);

      // size 10: 3 beats, last beat carries 2 bytes
      push(10);
      chk("t1_pending", bus.pending, 1);
      run_payload(3, 2, 0, "t1");
      tick;
      chk("t1_cv_drop", bus.checksum_valid, 0);

      // size 8 with gapped beats
      push(8);
      bus.data_start = 1'b1;
      tick;
      bus.data_start = 1'b0;
      chk("t2_busy", bus.busy, 1);
      chk("t2_last_bytes", bus.last_bytes, 4);
      bus.data_valid = 1'b1;
      #1;
      chk("t2_lb_first", bus.last_beat, 0);
      tick;
      bus.data_valid = 1'b0;
      #1;
      chk("t2_lb_gap", bus.last_beat, 0);
      tick;
      chk("t2_no_early_cv1", bus.checksum_valid, 0);
      tick;
      chk("t2_no_early_cv2", bus.checksum_valid, 0);
      bus.data_valid = 1'b1;
      #1;
      chk("t2_lb_final", bus.last_beat, 1);
      tick;
      bus.data_valid = 1'b0;
      #1;
      chk("t2_cv", bus.checksum_valid, 1);
      chk("t2_busy_end", bus.busy, 0);
      cv_exp++;
      tick;

      // zero-length payload, then a single-beat payload
      push(0);
      run_payload(0, 0, 0, "t3a");
      tick;
      chk("t3_busy_after", bus.busy, 0);
      chk("t3_cv_drop", bus.checksum_valid, 0);
      push(4);
      run_payload(1, 4, 0, "t3b");
      tick;

      // fill the queue, overflow the fifth push, then drain back-to-back
      for (int i = 0; i < 5; i++) begin
         chk("t4_size_ready", bus.size_ready, (i < 4));
         bus.size_valid = 1'b1;
         bus.size       = sizes[i];
         tick;
      end
      bus.size_valid = 1'b0;
      chk("t4_pending_full", bus.pending, 4);
      chk("t4_err_ovf", bus.err_overflow, 1);
      chk("t4_ready_full", bus.size_ready, 0);
      bus.err_clear = 1'b1;
      tick;
      bus.err_clear = 1'b0;
      chk("t4_err_ovf_clr", bus.err_overflow, 0);
      run_payload(2, 1, 3, "t4_s5");
      run_payload(2, 4, 2, "t4_s8");
      run_payload(3, 3, 1, "t4_s11");
      run_payload(4, 4, 0, "t4_s16");
      tick;
      chk("t4_pending_end", bus.pending, 0);
      chk("t4_busy_end", bus.busy, 0);

      // misplaced data_start in IDLE, clear priority, start mid-COUNT
      bus.data_start = 1'b1;
      tick;
      bus.data_start = 1'b0;
      chk("t5_err_idle", bus.err_start, 1);
      bus.err_clear  = 1'b1;
      bus.data_start = 1'b1;
      tick;
      bus.err_clear  = 1'b0;
      bus.data_start = 1'b0;
      chk("t5_clr_priority", bus.err_start, 0);
      push(12);
      bus.data_start = 1'b1;
      tick;
      bus.data_start = 1'b0;
      bus.data_valid = 1'b1;
      tick;
      bus.data_start = 1'b1;
      #1;
      chk("t5_lb_mid", bus.last_beat, 0);
      tick;
      bus.data_start = 1'b0;
      chk("t5_err_count", bus.err_start, 1);
      chk("t5_busy_kept", bus.busy, 1);
      #1;
      chk("t5_lb_final", bus.last_beat, 1);
      tick;
      bus.data_valid = 1'b0;
      #1;
      chk("t5_cv", bus.checksum_valid, 1);
      cv_exp++;
      bus.err_clear = 1'b1;
      tick;
      bus.err_clear = 1'b0;

      // push into empty queue with data_start in the same cycle
      bus.size_valid = 1'b1;
      bus.size       = 4;
      bus.data_start = 1'b1;
      tick;
      bus.size_valid = 1'b0;
      bus.data_start = 1'b0;
      chk("t5_err_push_start", bus.err_start, 1);
      chk("t5_pending_armed", bus.pending, 1);

      // simultaneous push and pop keeps pending unchanged
      bus.size_valid = 1'b1;
      bus.size       = 8;
      bus.data_start = 1'b1;
      tick;
      bus.size_valid = 1'b0;
      bus.data_start = 1'b0;
      chk("t5_pending_pushpop", bus.pending, 1);
      chk("t5_busy_pushpop", bus.busy, 1);
      chk("t5_lbytes_pushpop", bus.last_bytes, 4);
      bus.data_valid = 1'b1;
      #1;
      chk("t5_lb_pushpop", bus.last_beat, 1);
      tick;
      bus.data_valid = 1'b0;
      #1;
      chk("t5_cv_pushpop", bus.checksum_valid, 1);
      cv_exp++;
      run_payload(2, 4, 0, "t5_s8");
      tick;

      // reset in the middle of a long payload
      push(100);
      bus.data_start = 1'b1;
      tick;
      bus.data_start = 1'b0;
      bus.data_valid = 1'b1;
      repeat (5) tick;
      bus.data_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("t6_pending", bus.pending, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_cv", bus.checksum_valid, 0);
      chk("t6_size_ready", bus.size_ready, 1);
      chk("t6_err_start", bus.err_start, 0);
      tick;
      chk("t6_cv_after", bus.checksum_valid, 0);
      push(4);
      run_payload(1, 4, 0, "t6_s4");
      tick;
      tick;

      chk("cv_count", cv_seen, cv_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
